// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nandn_pkg.sv
// Tree geometry helpers for the pipelined wide NAND: level widths, stage count
// and the padding value for short groups.
package gf180mcu_fd_sc_mcu7t5v0__nandn_pkg;

    localparam logic PAD_BIT = 1'b1;

    function automatic int level_width(input int width, input int fanin, input int level);
        int w;
        w = width;
        for (int k = 0; k < level; k++) begin
            w = (w + fanin - 1) / fanin;
        end
        return w;
    endfunction

    function automatic int stage_count(input int width, input int fanin);
        int w;
        int n;
        w = width;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (w > 1) begin
                w = (w + fanin - 1) / fanin;
                n++;
            end
        end
        return n;
    endfunction

    function automatic int padded_width(input int width, input int fanin);
        return ((width + fanin - 1) / fanin) * fanin;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nandn_stage.sv
// One tree level: FANIN-wide group AND per channel, a registered result and a
// valid flag with the elastic ready rule (ready = empty or downstream ready).
module gf180mcu_fd_sc_mcu7t5v0__nandn_stage
    import gf180mcu_fd_sc_mcu7t5v0__nandn_pkg::*;
#(
    parameter int IN_W  = 9,
    parameter int FANIN = 3,
    parameter int NCH   = 1,
    parameter bit INV   = 1'b0
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NCH*IN_W-1:0]                           up_data,
    input  logic                                          up_valid,
    output logic                                          up_ready,
    output logic [NCH*level_width(IN_W, FANIN, 1)-1:0]    dn_data,
    output logic                                          dn_valid,
    input  logic                                          dn_ready
);

    localparam int OUT_W = level_width(IN_W, FANIN, 1);
    localparam int PAD_W = padded_width(IN_W, FANIN);
    // The inverting last level resets low so ZN idles at 0.
    localparam logic [NCH*OUT_W-1:0] RESET_DATA = {(NCH*OUT_W){~INV}};

    logic [NCH*OUT_W-1:0] reduced;
    logic                 valid;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [PAD_W-1:0] padded;

        always_comb begin
            padded = {PAD_W{PAD_BIT}};
            padded[IN_W-1:0] = up_data[c*IN_W +: IN_W];
        end

        for (genvar g = 0; g < OUT_W; g++) begin : g_grp
            assign reduced[c*OUT_W + g] = &padded[g*FANIN +: FANIN];
        end
    end

    assign up_ready = !valid || dn_ready;
    assign dn_valid = valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            dn_data <= RESET_DATA;
        end else begin
            if (up_ready) begin
                valid <= up_valid;
            end
            if (up_ready && up_valid) begin
                dn_data <= INV ? ~reduced : reduced;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nandn_pipe.sv
// Pipelined NCH-channel WIDTH-input NAND: one registered tree level per stage,
// ready/valid between stages, last level stored inverted to drive ZN.
module gf180mcu_fd_sc_mcu7t5v0__nandn_pipe
    import gf180mcu_fd_sc_mcu7t5v0__nandn_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int FANIN = 3,
    parameter int NCH   = 1
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic [NCH*WIDTH-1:0] A,
    input  logic                 I_VALID,
    output logic                 I_READY,
    output logic [NCH-1:0]       ZN,
    output logic                 O_VALID,
    input  logic                 O_READY,
    inout  wire                  VDD,
    inout  wire                  VSS
);

    localparam int STAGES = stage_count(WIDTH, FANIN);

    logic unused_supply;
    assign unused_supply = VDD ^ VSS;

    // Each level keeps its own handshake nets so the ready chain is a plain
    // cascade of separate signals rather than bits of one shared vector.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W  = level_width(WIDTH, FANIN, k);
        localparam int OUT_W = level_width(WIDTH, FANIN, k + 1);

        logic [NCH*IN_W-1:0]  up_data;
        logic [NCH*OUT_W-1:0] dn_data;
        logic                 up_valid;
        logic                 up_ready;
        logic                 dn_valid;
        logic                 dn_ready;

        if (k == 0) begin : g_first
            assign up_data  = A;
            assign up_valid = I_VALID;
        end else begin : g_next
            assign up_data  = g_stage[k-1].dn_data;
            assign up_valid = g_stage[k-1].dn_valid;
        end

        if (k == STAGES - 1) begin : g_last
            assign dn_ready = O_READY;
        end else begin : g_inner
            assign dn_ready = g_stage[k+1].up_ready;
        end

        gf180mcu_fd_sc_mcu7t5v0__nandn_stage #(
            .IN_W  (IN_W),
            .FANIN (FANIN),
            .NCH   (NCH),
            .INV   (k == STAGES - 1)
        ) u_stage (
            .clk      (CLK),
            .rst_n    (RN),
            .up_data  (up_data),
            .up_valid (up_valid),
            .up_ready (up_ready),
            .dn_data  (dn_data),
            .dn_valid (dn_valid),
            .dn_ready (dn_ready)
        );
    end

    assign I_READY = g_stage[0].up_ready;
    assign O_VALID = g_stage[STAGES-1].dn_valid;
    assign ZN      = g_stage[STAGES-1].dn_data;

endmodule
